ps2_kb_ascii_fifo: RTL

- Next-generation keyboard front end: PS/2 frame receiver, Set-2 scan-code decoder with make/break/extended tracking, Shift/Caps Lock modifier state, and a parametrised ASCII FIFO in one block.
- Delivers translated characters only. Break codes and unmapped keys are consumed internally.
- Sits between the PS/2 pins and the text/console logic, which pops characters with DoRead.

---
 rtl/ps2_kb_ascii_fifo.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kb_ascii_fifo.sv
// PS/2 keyboard front end: pin synchronisers, clock glitch filter, frame receiver,
// Set-2 make/break decoder with Shift/Caps tracking, and an ASCII FIFO.
//
// state   | meaning
// IDLE    | waiting for a code or prefix
// EXT     | E0 seen, next code is an extended key
// BRK     | F0 seen, next code is a key release
// EXT_BRK | E0 F0 seen, next code is an extended release
module ps2_kb_ascii_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       DoRead,
    output logic [7:0] ascii_code,
    output logic       kb_buf_empty,
    output logic       kb_buf_full,
    output logic       caps_lock,
    output logic       shift_held,
    output logic       rx_error,
    output logic       overflow
);
    localparam int FCW   = $clog2(FILTER_LEN + 1);
    localparam int TCW   = $clog2(TIMEOUT_CYC + 1);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_t;

    logic [1:0]         c_sync, d_sync;
    logic [FCW-1:0]     flt_cnt;
    logic               c_flt, c_flt_q, fall;
    logic [9:0]         shreg;
    logic [10:0]        frame;
    logic [3:0]         bit_cnt;
    logic [TCW-1:0]     idle_cnt;
    logic               byte_stb, frame_ok;
    logic [7:0]         byte_data;
    dec_state_t         state, state_nx;
    logic               make_stb, brk_stb;
    logic               shift_l, shift_r, caps_down;
    logic [7:0]         lc, dlo, dhi, misc, chr;
    logic               chr_vld, wr_req, do_wr, do_rd;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            flt_cnt <= FCW'(FILTER_LEN - 1);
            c_flt   <= 1'b1;
            c_flt_q <= 1'b1;
        end else begin
            c_flt_q <= c_flt;
            if (c_sync[1] == c_flt) begin
                flt_cnt <= FCW'(FILTER_LEN - 1);
            end else if (flt_cnt == '0) begin
                c_flt   <= c_sync[1];
                flt_cnt <= FCW'(FILTER_LEN - 1);
            end else begin
                flt_cnt <= flt_cnt - 1'b1;
            end
        end
    end

    assign fall     = c_flt_q & ~c_flt;
    assign frame    = {d_sync[1], shreg};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= TCW'(TIMEOUT_CYC - 1);
            byte_stb  <= 1'b0;
            byte_data <= '0;
            rx_error  <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            rx_error <= 1'b0;
            if (fall) begin
                idle_cnt <= TCW'(TIMEOUT_CYC - 1);
                if (bit_cnt == 4'd10) begin
                    bit_cnt   <= '0;
                    byte_stb  <= frame_ok;
                    rx_error  <= ~frame_ok;
                    byte_data <= frame[8:1];
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg   <= frame[10:1];
                end
            end else begin
                if (idle_cnt != '0) idle_cnt <= idle_cnt - 1'b1;
                else if (bit_cnt != '0) bit_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        make_stb = 1'b0;
        brk_stb  = 1'b0;
        if (byte_stb) begin
            case (state)
                ST_IDLE: begin
                    if (byte_data == 8'hE0)      state_nx = ST_EXT;
                    else if (byte_data == 8'hF0) state_nx = ST_BRK;
                    else                         make_stb = 1'b1;
                end
                ST_EXT:  state_nx = (byte_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK: begin
                    brk_stb  = 1'b1;
                    state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // caps_down blocks typematic repeats of Caps Lock from toggling again
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_lock <= 1'b0;
            caps_down <= 1'b0;
        end else if (make_stb) begin
            case (byte_data)
                8'h12: shift_l <= 1'b1;
                8'h59: shift_r <= 1'b1;
                8'h58: begin
                    if (!caps_down) caps_lock <= ~caps_lock;
                    caps_down <= 1'b1;
                end
                default: ;
            endcase
        end else if (brk_stb) begin
            case (byte_data)
                8'h12: shift_l   <= 1'b0;
                8'h59: shift_r   <= 1'b0;
                8'h58: caps_down <= 1'b0;
                default: ;
            endcase
        end
    end

    assign shift_held = shift_l | shift_r;

    always_comb begin
        lc   = '0;
        dlo  = '0;
        dhi  = '0;
        misc = '0;
        case (byte_data)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            8'h45: begin dlo = "0"; dhi = ")"; end
            8'h16: begin dlo = "1"; dhi = "!"; end
            8'h1E: begin dlo = "2"; dhi = "@"; end
            8'h26: begin dlo = "3"; dhi = "#"; end
            8'h25: begin dlo = "4"; dhi = "$"; end
            8'h2E: begin dlo = "5"; dhi = "%"; end
            8'h36: begin dlo = "6"; dhi = "^"; end
            8'h3D: begin dlo = "7"; dhi = "&"; end
            8'h3E: begin dlo = "8"; dhi = "*"; end
            8'h46: begin dlo = "9"; dhi = "("; end
            8'h29: misc = 8'h20;
            8'h5A: misc = 8'h0D;
            8'h66: misc = 8'h08;
            8'h0D: misc = 8'h09;
            8'h76: misc = 8'h1B;
            default: ;
        endcase
        chr_vld = 1'b1;
        if (lc != '0)        chr = (shift_held ^ caps_lock) ? lc - 8'h20 : lc;
        else if (dlo != '0)  chr = shift_held ? dhi : dlo;
        else if (misc != '0) chr = misc;
        else begin
            chr     = '0;
            chr_vld = 1'b0;
        end
    end

    assign wr_req       = make_stb & chr_vld;
    assign kb_buf_empty = (count == '0);
    assign kb_buf_full  = (count == (FIFO_AW + 1)'(DEPTH));
    assign do_rd        = DoRead & ~kb_buf_empty;
    assign do_wr        = wr_req & (~kb_buf_full | do_rd);
    assign ascii_code   = kb_buf_empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= chr;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (wr_req && kb_buf_full && !DoRead) overflow <= 1'b1;
        end
    end
endmodule
